// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the shared CPU memory bus; one whole transaction per grant.
// Optional bus timeout enabled by defining ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [AW-1:0] m0_address_i,
    input  logic          m0_rw_req_i,
    input  logic          m0_rw_i,
    input  logic [DW-1:0] m0_write_data_i,
    input  logic [1:0]    m0_size_i,
    output logic [DW-1:0] m0_read_data_o,
    output logic          m0_rec_o,
    input  logic [AW-1:0] m1_address_i,
    input  logic          m1_rw_req_i,
    input  logic          m1_rw_i,
    input  logic [DW-1:0] m1_write_data_i,
    input  logic [1:0]    m1_size_i,
    output logic [DW-1:0] m1_read_data_o,
    output logic          m1_rec_o,
    output logic [AW-1:0] s_address_o,
    output logic          s_rw_req_o,
    output logic          s_rw_o,
    output logic [DW-1:0] s_write_data_o,
    output logic [1:0]    s_size_o,
    input  logic [DW-1:0] s_read_data_i,
    input  logic          s_rec_i,
    output logic [1:0]    grant_o,
    output logic          bus_err_o,
    input  logic          err_clr_i
);

    // state   | meaning
    // IDLE    | bus free, arbitrating between pending requests
    // GRANT0  | master 0 owns the bus until completion
    // GRANT1  | master 1 owns the bus until completion
    // RELEASE | one dead cycle; lets the slave drop its completion
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT0  = 2'd1;
    localparam logic [1:0] ST_GRANT1  = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic [DW-1:0] TMO_DATA = DW'(32'hDEADBEEF);

    logic [1:0] state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       in_g0, in_g1, tmo_hit, done;

    assign in_g0 = (state_q == ST_GRANT0);
    assign in_g1 = (state_q == ST_GRANT1);
    assign done  = s_rec_i | tmo_hit;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          bus_err_q, bus_err_d;

    assign tmo_hit   = (in_g0 | in_g1) & ~s_rec_i & (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign tmo_cnt_d = ((in_g0 | in_g1) & ~s_rec_i) ? tmo_cnt_q + 1'b1 : '0;
    // A timeout in the same cycle as err_clr keeps the flag set.
    assign bus_err_d = tmo_hit ? 1'b1 : (err_clr_i ? 1'b0 : bus_err_q);
    assign bus_err_o = bus_err_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_cnt_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            bus_err_q <= bus_err_d;
        end
    end
`else
    logic unused_cfg;

    assign tmo_hit    = 1'b0;
    assign bus_err_o  = 1'b0;
    assign unused_cfg = err_clr_i | (TIMEOUT_CYCLES < 2);
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_rw_req_i && m1_rw_req_i)
                    state_d = last_grant_q ? ST_GRANT0 : ST_GRANT1;
                else if (m0_rw_req_i)
                    state_d = ST_GRANT0;
                else if (m1_rw_req_i)
                    state_d = ST_GRANT1;
            end
            ST_GRANT0: begin
                if (done) begin
                    last_grant_d = 1'b0;
                    state_d      = ST_RELEASE;
                end
            end
            ST_GRANT1: begin
                if (done) begin
                    last_grant_d = 1'b1;
                    state_d      = ST_RELEASE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign grant_o        = {in_g1, in_g0};
    assign s_address_o    = in_g0 ? m0_address_i    : (in_g1 ? m1_address_i    : '0);
    assign s_rw_req_o     = in_g0 ? m0_rw_req_i     : (in_g1 ? m1_rw_req_i     : 1'b0);
    assign s_rw_o         = in_g0 ? m0_rw_i         : (in_g1 ? m1_rw_i         : 1'b0);
    assign s_write_data_o = in_g0 ? m0_write_data_i : (in_g1 ? m1_write_data_i : '0);
    assign s_size_o       = in_g0 ? m0_size_i       : (in_g1 ? m1_size_i       : 2'b00);

    assign m0_rec_o       = in_g0 & done;
    assign m1_rec_o       = in_g1 & done;
    assign m0_read_data_o = m0_rec_o ? (s_rec_i ? s_read_data_i : TMO_DATA) : '0;
    assign m1_read_data_o = m1_rec_o ? (s_rec_i ? s_read_data_i : TMO_DATA) : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; inputs change 1 ns after the rising edge, outputs checked 1 ns later.
// Build with ARB_TIMEOUT_EN defined to exercise the timeout path (TIMEOUT_CYCLES = 8).
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_address, m1_address, m0_write_data, m1_write_data;
    logic        m0_rw_req, m1_rw_req, m0_rw, m1_rw;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_read_data, m1_read_data;
    logic        m0_rec, m1_rec;
    logic [31:0] s_address, s_write_data, s_read_data;
    logic        s_rw_req, s_rw, s_rec;
    logic [1:0]  s_size, grant;
    logic        bus_err, err_clr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .m0_address_i(m0_address), .m0_rw_req_i(m0_rw_req), .m0_rw_i(m0_rw),
        .m0_write_data_i(m0_write_data), .m0_size_i(m0_size),
        .m0_read_data_o(m0_read_data), .m0_rec_o(m0_rec),
        .m1_address_i(m1_address), .m1_rw_req_i(m1_rw_req), .m1_rw_i(m1_rw),
        .m1_write_data_i(m1_write_data), .m1_size_i(m1_size),
        .m1_read_data_o(m1_read_data), .m1_rec_o(m1_rec),
        .s_address_o(s_address), .s_rw_req_o(s_rw_req), .s_rw_o(s_rw),
        .s_write_data_o(s_write_data), .s_size_o(s_size),
        .s_read_data_i(s_read_data), .s_rec_i(s_rec),
        .grant_o(grant), .bus_err_o(bus_err), .err_clr_i(err_clr)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; err_clr = 1'b0;
        m0_address = '0; m0_rw_req = 0; m0_rw = 0; m0_write_data = '0; m0_size = '0;
        m1_address = '0; m1_rw_req = 0; m1_rw = 0; m1_write_data = '0; m1_size = '0;
        s_read_data = '0; s_rec = 0;
        tick(); tick();
        settle();
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_rw_req", s_rw_req, 0);
        chk("rst_m0_rec", m0_rec, 0);
        chk("rst_bus_err", bus_err, 0);
        rst_n = 1'b1;
        tick();

        // contention from reset: m0 wins first tie
        m0_address = 32'h0000_0200; m0_rw_req = 1;
        m1_address = 32'h0000_0300; m1_rw_req = 1;
        settle();
        chk("cont_idle_grant", grant, 2'b00);
        tick(); settle();
        chk("cont1_grant", grant, 2'b01);
        chk("cont1_addr", s_address, 32'h0000_0200);
        s_rec = 1; s_read_data = 32'hAAAA_0000; settle();
        chk("cont1_m0_rec", m0_rec, 1);
        chk("cont1_m0_data", m0_read_data, 32'hAAAA_0000);
        chk("cont1_m1_rec", m1_rec, 0);
        chk("cont1_m1_data", m1_read_data, 0);
        tick(); s_rec = 0; m0_rw_req = 0; settle();
        chk("cont1_release", grant, 2'b00);
        tick(); settle();
        chk("cont1_idle", grant, 2'b00);
        tick(); settle();
        chk("cont2_grant", grant, 2'b10);
        chk("cont2_addr", s_address, 32'h0000_0300);
        s_rec = 1; s_read_data = 32'hBBBB_0000; settle();
        chk("cont2_m1_rec", m1_rec, 1);
        chk("cont2_m1_data", m1_read_data, 32'hBBBB_0000);
        chk("cont2_m0_rec", m0_rec, 0);
        tick(); s_rec = 0; m1_rw_req = 0; settle();
        tick();
        // both again: last served was m1, so m0 goes next
        m0_rw_req = 1; m1_rw_req = 1;
        tick(); settle();
        chk("cont3_grant", grant, 2'b01);
        s_rec = 1; s_read_data = 32'h1; settle();
        chk("cont3_m0_rec", m0_rec, 1);
        tick(); s_rec = 0; m0_rw_req = 0;
        tick(); tick(); settle();
        chk("cont4_grant", grant, 2'b10);
        s_rec = 1; settle();
        tick(); s_rec = 0; m1_rw_req = 0;
        tick(); tick(); settle();
        chk("cont_done_idle", grant, 2'b00);

        // single read, completion two cycles after grant
        m0_address = 32'h0000_0100; m0_rw = 0; m0_size = 2'd2; m0_rw_req = 1;
        tick(); settle();
        chk("rd_grant", grant, 2'b01);
        chk("rd_s_rw_req", s_rw_req, 1);
        chk("rd_s_addr", s_address, 32'h0000_0100);
        chk("rd_s_rw", s_rw, 0);
        tick(); settle();
        chk("rd_no_rec_yet", m0_rec, 0);
        tick();
        s_rec = 1; s_read_data = 32'h1234_5678; settle();
        chk("rd_m0_rec", m0_rec, 1);
        chk("rd_m0_data", m0_read_data, 32'h1234_5678);
        chk("rd_m1_rec", m1_rec, 0);
        chk("rd_m1_data", m1_read_data, 0);
        tick(); s_rec = 0; m0_rw_req = 0; settle();
        chk("rd_release_grant", grant, 2'b00);
        chk("rd_release_rec", m0_rec, 0);
        chk("rd_release_req", s_rw_req, 0);
        tick(); settle();
        chk("rd_idle", grant, 2'b00);

        // slave holds completion three cycles
        m1_address = 32'h0000_0400; m1_rw_req = 1;
        tick(); settle();
        chk("hold_grant", grant, 2'b10);
        s_rec = 1; s_read_data = 32'hCAFE_F00D; settle();
        chk("hold_rec1", m1_rec, 1);
        chk("hold_data1", m1_read_data, 32'hCAFE_F00D);
        tick(); m1_rw_req = 0; settle();
        chk("hold_rec2", m1_rec, 0);
        chk("hold_data2", m1_read_data, 0);
        chk("hold_grant2", grant, 2'b00);
        tick(); settle();
        chk("hold_rec3", m1_rec, 0);
        chk("hold_grant3", grant, 2'b00);
        chk("hold_s_rw_req3", s_rw_req, 0);
        tick(); s_rec = 0; settle();
        chk("hold_after", grant, 2'b00);

        // write pass-through, then protocol violation (request dropped early)
        m0_address = 32'h5555_5555; m0_write_data = 32'h6666_6666; m0_size = 2'd1; m0_rw = 1;
        m1_address = 32'h8000_0004; m1_write_data = 32'h0000_000F; m1_size = 2'd2; m1_rw = 1;
        m1_rw_req = 1;
        tick(); settle();
        chk("wr_grant", grant, 2'b10);
        chk("wr_s_addr", s_address, 32'h8000_0004);
        chk("wr_s_data", s_write_data, 32'h0000_000F);
        chk("wr_s_size", s_size, 2'd2);
        chk("wr_s_rw", s_rw, 1);
        chk("wr_s_rw_req", s_rw_req, 1);
        s_read_data = 32'h7777_7777; settle();
        chk("wr_m1_data_norec", m1_read_data, 0);
        chk("wr_m0_rec", m0_rec, 0);
        chk("wr_m0_data", m0_read_data, 0);
        tick(); m1_rw_req = 0; settle();
        chk("viol_grant_kept", grant, 2'b10);
        chk("viol_s_rw_req", s_rw_req, 0);
        tick(); settle();
        chk("viol_grant_kept2", grant, 2'b10);
        s_rec = 1; settle();
        chk("viol_m1_rec", m1_rec, 1);
        tick(); s_rec = 0; m1_rw = 0;
        tick(); settle();
        chk("viol_idle", grant, 2'b00);
        m0_rw = 0;

`ifdef ARB_TIMEOUT_EN
        m0_address = 32'h0000_0100; m0_rw_req = 1;
        tick();
        for (int i = 1; i <= 7; i++) begin
            settle();
            chk($sformatf("tmo_wait%0d", i), {grant, m0_rec}, {2'b01, 1'b0});
            tick();
        end
        settle();
        chk("tmo_m0_rec", m0_rec, 1);
        chk("tmo_m0_data", m0_read_data, 32'hDEAD_BEEF);
        chk("tmo_err_before", bus_err, 0);
        tick(); m0_rw_req = 0; settle();
        chk("tmo_release", grant, 2'b00);
        chk("tmo_err_set", bus_err, 1);
        tick(); tick(); settle();
        chk("tmo_err_sticky", bus_err, 1);
        err_clr = 1;
        tick(); err_clr = 0; settle();
        chk("tmo_err_clr", bus_err, 0);
        // timeout cycle with s_rec: normal completion
        m0_rw_req = 1;
        tick();
        repeat (7) tick();
        s_rec = 1; s_read_data = 32'h0BAD_F00D; settle();
        chk("tmo_race_rec", m0_rec, 1);
        chk("tmo_race_data", m0_read_data, 32'h0BAD_F00D);
        tick(); s_rec = 0; m0_rw_req = 0; settle();
        chk("tmo_race_err", bus_err, 0);
        tick();
        // timeout together with err_clr keeps the flag
        m1_rw_req = 1;
        tick();
        repeat (7) tick();
        err_clr = 1; settle();
        chk("tmo_clr_rec", m1_rec, 1);
        tick(); err_clr = 0; m1_rw_req = 0; settle();
        chk("tmo_clr_err", bus_err, 1);
        err_clr = 1; tick(); err_clr = 0; tick();
`else
        // hung slave keeps the grant; error flag never moves
        m0_address = 32'h0000_0100; m0_rw_req = 1; err_clr = 1;
        tick(); err_clr = 0;
        repeat (20) tick();
        settle();
        chk("hung_grant", grant, 2'b01);
        chk("hung_rec", m0_rec, 0);
        chk("hung_err", bus_err, 0);
        s_rec = 1; s_read_data = 32'h4242_4242; settle();
        chk("hung_done", m0_read_data, 32'h4242_4242);
        tick(); s_rec = 0; m0_rw_req = 0;
        tick();
`endif

        // reset mid-GRANT1
        m1_rw_req = 1;
        tick(); settle();
        chk("rstm_grant_before", grant, 2'b10);
        rst_n = 0; s_rec = 1; s_read_data = 32'h9999_9999; settle();
        chk("rstm_grant", grant, 2'b00);
        chk("rstm_s_rw_req", s_rw_req, 0);
        chk("rstm_m1_rec", m1_rec, 0);
        chk("rstm_m1_data", m1_read_data, 0);
        chk("rstm_bus_err", bus_err, 0);
        tick(); s_rec = 0; m1_rw_req = 0; rst_n = 1;
        // after reset m0 wins the tie again
        m0_rw_req = 1; m1_rw_req = 1;
        tick(); settle();
        chk("rstm_tie_grant", grant, 2'b01);
        m0_rw_req = 0; m1_rw_req = 0;
        s_rec = 1; tick(); s_rec = 0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
